// File: rtl/conv3_tile_fetch.sv
// rtl/conv3_tile_fetch.sv - builds 4x4 conv windows from 3x3 neighbour 2x2-block SRAM words
// Define TILE_FETCH_PAD_EN to cover border tiles with zero padding.
module conv3_tile_fetch #(
  parameter int BW_PER_ACT   = 12,
  parameter int ACT_PER_ADDR = 4,
  parameter int MAP_BLK      = 14,
  parameter int ADDR_W       = 10
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [ADDR_W-1:0]                  base_addr,
  output logic                               busy,
  output logic                               done,
  output logic                               sram_re,
  output logic [ADDR_W-1:0]                  sram_raddr,
  input  logic [BW_PER_ACT*ACT_PER_ADDR-1:0] sram_rdata,
  output logic                               tile_valid,
  input  logic                               tile_ready,
  output logic [16*BW_PER_ACT-1:0]           tile_data,
  output logic [7:0]                         tile_row,
  output logic [7:0]                         tile_col
);

  localparam int TILE_W = 16 * BW_PER_ACT;
`ifdef TILE_FETCH_PAD_EN
  localparam logic [7:0] FIRST = 8'd0;
  localparam logic [7:0] LAST  = 8'(MAP_BLK - 1);
`else
  localparam logic [7:0] FIRST = 8'd1;
  localparam logic [7:0] LAST  = 8'(MAP_BLK - 2);
`endif

  typedef enum logic [2:0] {IDLE, READ, WAIT, OUT, DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          k_q, k_d, cap_k_q, cap_k_d;
  logic [7:0]          bi_q, bi_d, bj_q, bj_d;
  logic [7:0]          tile_row_q, tile_row_d, tile_col_q, tile_col_d;
  logic [ADDR_W-1:0]   base_q, base_d, sram_raddr_q, sram_raddr_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                sram_re_q, sram_re_d, tile_valid_q, tile_valid_d;
  logic                cap_act_q, cap_act_d, cap_re_q, cap_re_d;
  logic [TILE_W-1:0]   tile_data_q, tile_data_d;

  assign busy       = busy_q;
  assign done       = done_q;
  assign sram_re    = sram_re_q;
  assign sram_raddr = sram_raddr_q;
  assign tile_valid = tile_valid_q;
  assign tile_data  = tile_data_q;
  assign tile_row   = tile_row_q;
  assign tile_col   = tile_col_q;

  always_comb begin
    int   nbi, nbj, wr, wc;
    logic inb;
    state_d      = state_q;
    k_d          = k_q;
    bi_d         = bi_q;
    bj_d         = bj_q;
    base_d       = base_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    tile_valid_d = tile_valid_q;
    tile_row_d   = tile_row_q;
    tile_col_d   = tile_col_q;
    tile_data_d  = tile_data_q;
    cap_act_d    = (state_q == READ);
    cap_k_d      = k_q;
    cap_re_d     = sram_re_q;
    sram_re_d    = 1'b0;
    sram_raddr_d = '0;
    nbi = 0;
    nbj = 0;
    wr  = 0;
    wc  = 0;
    inb = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          k_d     = 4'd0;
          bi_d    = FIRST;
          bj_d    = FIRST;
          base_d  = base_addr;
          busy_d  = 1'b1;
        end
      end
      READ: begin
        if (k_q == 4'd8) state_d = WAIT;
        else             k_d = k_q + 4'd1;
      end
      WAIT: begin
        state_d      = OUT;
        tile_valid_d = 1'b1;
        tile_row_d   = bi_q;
        tile_col_d   = bj_q;
      end
      OUT: begin
        if (tile_ready) begin
          tile_valid_d = 1'b0;
          if (bi_q == LAST && bj_q == LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = READ;
            k_d     = 4'd0;
            if (bj_q == LAST) begin
              bj_d = FIRST;
              bi_d = bi_q + 8'd1;
            end else begin
              bj_d = bj_q + 8'd1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // The word read last cycle lands in the window; skipped neighbours become zeros.
    if (cap_act_q) begin
      for (int br = 0; br < 2; br++) begin
        for (int bc = 0; bc < 2; bc++) begin
          wr = 2 * (int'(cap_k_q) / 3) + br - 1;
          wc = 2 * (int'(cap_k_q) % 3) + bc - 1;
          if (wr >= 0 && wr <= 3 && wc >= 0 && wc <= 3)
            tile_data_d[(16 - 4*wr - wc)*BW_PER_ACT - 1 -: BW_PER_ACT] =
              cap_re_q ? sram_rdata[(4 - 2*br - bc)*BW_PER_ACT - 1 -: BW_PER_ACT] : '0;
        end
      end
    end

    nbi = int'(bi_d) + int'(k_d) / 3 - 1;
    nbj = int'(bj_d) + int'(k_d) % 3 - 1;
`ifdef TILE_FETCH_PAD_EN
    inb = (nbi >= 0) && (nbi < MAP_BLK) && (nbj >= 0) && (nbj < MAP_BLK);
`else
    inb = 1'b1;
`endif
    if (state_d == READ && inb) begin
      sram_re_d    = 1'b1;
      sram_raddr_d = base_d + ADDR_W'(nbi * MAP_BLK + nbj);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      cap_k_q      <= '0;
      bi_q         <= '0;
      bj_q         <= '0;
      tile_row_q   <= '0;
      tile_col_q   <= '0;
      base_q       <= '0;
      sram_raddr_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sram_re_q    <= 1'b0;
      tile_valid_q <= 1'b0;
      cap_act_q    <= 1'b0;
      cap_re_q     <= 1'b0;
      tile_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cap_k_q      <= cap_k_d;
      bi_q         <= bi_d;
      bj_q         <= bj_d;
      tile_row_q   <= tile_row_d;
      tile_col_q   <= tile_col_d;
      base_q       <= base_d;
      sram_raddr_q <= sram_raddr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sram_re_q    <= sram_re_d;
      tile_valid_q <= tile_valid_d;
      cap_act_q    <= cap_act_d;
      cap_re_q     <= cap_re_d;
      tile_data_q  <= tile_data_d;
    end
  end

endmodule

// File: tb/tb_conv3_tile_fetch.sv
// tb/tb_conv3_tile_fetch.sv - directed self-checking bench for conv3_tile_fetch (MAP_BLK=4)
module tb_conv3_tile_fetch;
  localparam int MB   = 4;
  localparam int BASE = 100;
`ifdef TILE_FETCH_PAD_EN
  localparam int FIRST = 0, LAST = MB - 1, N_READS = 100, FIRST_READS = 4;
  int exp_addr [9] = '{100, 101, 104, 105, 0, 0, 0, 0, 0};
`else
  localparam int FIRST = 1, LAST = MB - 2, N_READS = 36, FIRST_READS = 9;
  int exp_addr [9] = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
`endif
  localparam int W  = LAST - FIRST + 1;
  localparam int NT = W * W;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, tile_ready = 1'b0;
  logic [9:0]   base_addr = 10'd0;
  logic         busy, done, sram_re, tile_valid;
  logic [9:0]   sram_raddr;
  logic [47:0]  sram_rdata = '0;
  logic [191:0] tile_data, hold;
  logic [7:0]   tile_row, tile_col;

  int n_cmp = 0, n_fail = 0;
  int rd_addr [$];
  int raddr_bad = 0;
  int n_tiles, last_c, rd0;
  logic stall_ok, got_done;

  conv3_tile_fetch #(.BW_PER_ACT(12), .ACT_PER_ADDR(4), .MAP_BLK(MB), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .busy(busy), .done(done),
    .sram_re(sram_re), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_data(tile_data),
    .tile_row(tile_row), .tile_col(tile_col)
  );

  always #5 clk = ~clk;

  // Word at address a holds a in all four pixels; unread cycles return all-ones.
  always @(posedge clk) sram_rdata <= sram_re ? {4{12'(sram_raddr)}} : {4{12'hFFF}};

  always @(negedge clk) begin
    if (sram_re) rd_addr.push_back(int'(sram_raddr));
    else if (sram_raddr !== 10'd0) raddr_bad++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_pix(int bi, int bj, int r, int c);
    int nbi, nbj;
    nbi = bi + (r + 1) / 2 - 1;
    nbj = bj + (c + 1) / 2 - 1;
    if (nbi < 0 || nbi >= MB || nbj < 0 || nbj >= MB) return 12'd0;
    return 12'(BASE + nbi * MB + nbj);
  endfunction

  task automatic check_tile(input int bi, input int bj);
    logic [191:0] e;
    e = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        e[191 - 12*(4*r + c) -: 12] = exp_pix(bi, bj, r, c);
    chk("tile_row", tile_row, bi);
    chk("tile_col", tile_col, bj);
    chk("tile_data", tile_data, e);
    if (bi == 1 && bj == 1) begin
      chk("t11_p00", tile_data[191 -: 12], 100);
      chk("t11_p11", tile_data[191 - 12*5 -: 12], 105);
      chk("t11_p33", tile_data[11:0], 110);
    end
  endtask

  initial begin
    base_addr = 10'd100;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sram_re", sram_re, 0);
    chk("rst_raddr", sram_raddr, 0);
    chk("rst_valid", tile_valid, 0);
    chk("rst_data", tile_data, 0);
    chk("rst_row", tile_row, 0);
    chk("rst_col", tile_col, 0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // First tile, held for 20 cycles with tile_ready low
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    repeat (9) step();
    chk("valid_early", tile_valid, 0);
    step();
    chk("valid_at_11", tile_valid, 1);
    chk("first_read_count", rd_addr.size(), FIRST_READS);
    for (int i = 0; i < FIRST_READS; i++)
      if (i < rd_addr.size()) chk("first_raddr", rd_addr[i], exp_addr[i]);
    check_tile(FIRST, FIRST);
`ifdef TILE_FETCH_PAD_EN
    chk("pad_row0_zero", tile_data[191:144], 0);
    chk("pad_col0_zero", {tile_data[143 -: 12], tile_data[95 -: 12], tile_data[47 -: 12]}, 0);
`endif
    hold     = tile_data;
    rd0      = rd_addr.size();
    stall_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tile_valid !== 1'b1 || tile_data !== hold || tile_row !== 8'(FIRST)) stall_ok = 1'b0;
    end
    chk("stall_hold", stall_ok, 1);
    chk("stall_no_reads", rd_addr.size(), rd0);

    // Remaining tiles with tile_ready high; start re-pulsed mid-pass
    tile_ready = 1'b1;
    n_tiles    = 1;
    last_c     = 0;
    got_done   = 1'b0;
    for (int c = 1; c <= 600 && !got_done; c++) begin
      step();
      start = (c == 25);
      if (tile_valid) begin
        chk("tile_spacing", c - last_c, 11);
        last_c = c;
        check_tile(FIRST + n_tiles / W, FIRST + n_tiles % W);
        n_tiles++;
      end
      if (done) begin
        got_done = 1'b1;
        chk("busy_at_done", busy, 1);
      end
    end
    start = 1'b0;
    chk("done_seen", got_done, 1);
    chk("tile_count", n_tiles, NT);
    step();
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("total_reads", rd_addr.size(), N_READS);
    chk("raddr_zero_when_idle", raddr_bad, 0);
    repeat (15) step();
    chk("no_restart_valid", tile_valid, 0);
    chk("no_restart_busy", busy, 0);

    // Asynchronous reset at READ k=4 of the third tile
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (26) step();
    chk("pre_reset_re", sram_re, 1);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_re", sram_re, 0);
    chk("arst_raddr", sram_raddr, 0);
    chk("arst_valid", tile_valid, 0);
    chk("arst_data", tile_data, 0);
    chk("arst_row", tile_row, 0);
    chk("arst_col", tile_col, 0);
    chk("arst_done", done, 0);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("post_reset_idle", busy, 0);
    chk("post_reset_valid", tile_valid, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("restart_valid", tile_valid, 1);
    check_tile(FIRST, FIRST);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
